// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
//   Round-robin scheduler sharing one SPI transmitter between NUM_REQ requesters.
//   One word is accepted from the granted requester and offered to the transmitter
//   as a one-entry FIFO. The block sequences start/pop/busy and then holds an idle
//   gap of GAP_CYCLES cycles before the next grant.
// Ports
//   clock_i          system clock, all logic on posedge
//   reset_i          synchronous, active-high reset
//   enable_i         1 = new grants allowed
//   req_valid_i      per-requester word available
//   req_data_i       word r at [r*DATA_W +: DATA_W]
//   req_ready_o      one-hot accept strobe (handshake = valid & ready)
//   tx_data_o        word presented to the transmitter
//   tx_fifo_empty_o  transmitter fifo_empty
//   tx_start_o       transmitter start_transmit
//   tx_fifo_read_i   transmitter pop strobe
//   tx_spi_busy_i    transmitter busy flag
//   grant_id_o       requester owning the current/last frame
//   frame_done_o     1-cycle pulse when the frame ends
//   arb_busy_o       arbiter not idle
module spi_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_W     = 24,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic                         enable_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic [DATA_W-1:0]            tx_data_o,
   output logic                         tx_fifo_empty_o,
   output logic                         tx_start_o,
   input  logic                         tx_fifo_read_i,
   input  logic                         tx_spi_busy_i,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
   output logic                         frame_done_o,
   output logic                         arb_busy_o
);

   localparam int unsigned IdW = $clog2(NUM_REQ);
   localparam logic [7:0] GapLoad = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StOffer, StWaitBusy, StGap} state_e;

   state_e              state_q, state_d;
   logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]      grant_id_q, grant_id_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [7:0]          gap_cnt_q, gap_cnt_d;

   logic                grant_found;
   logic [IdW-1:0]      grant_idx;
   logic [IdW-1:0]      cand;
   logic [DATA_W-1:0]   grant_data;

   // First valid requester starting at rr_ptr_q, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (IdW'(r) == grant_idx) begin
            grant_data = req_data_i[r*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      grant_id_d      = grant_id_q;
      hold_d          = hold_q;
      gap_cnt_d       = gap_cnt_q;
      req_ready_o     = '0;
      tx_fifo_empty_o = 1'b1;
      tx_start_o      = 1'b0;
      frame_done_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Ready is masked during reset so no handshake completes that cycle.
            if (enable_i && grant_found && !reset_i) begin
               req_ready_o[grant_idx] = 1'b1;
               hold_d                 = grant_data;
               grant_id_d             = grant_idx;
               rr_ptr_d               = (grant_idx == IdW'(NUM_REQ - 1)) ? '0
                                                                         : grant_idx + 1'b1;
               state_d                = StOffer;
            end
         end
         StOffer: begin
            tx_fifo_empty_o = 1'b0;
            tx_start_o      = 1'b1;
            if (tx_fifo_read_i) begin
               state_d = StWaitBusy;
            end
         end
         StWaitBusy: begin
            if (!tx_spi_busy_i) begin
               // A frame cut short by reset is dropped without a done pulse.
               frame_done_o = !reset_i;
               if (GAP_CYCLES == 0) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StGap;
                  gap_cnt_d = GapLoad;
               end
            end
         end
         StGap: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         hold_q     <= '0;
         gap_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         hold_q     <= hold_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign tx_data_o  = hold_q;
   assign grant_id_o = grant_id_q;
   assign arb_busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Testbench for spi_tx_arbiter: directed opening sequence (single requester,
// reset mid-frame, fairness) followed by randomized traffic, all checked each
// cycle against a transaction-level model of the arbiter.
module tb_spi_tx_arbiter;

   localparam int N = 4;
   localparam int W = 24;
   localparam int G = 2;
   localparam int NCYC = 3200;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic [N-1:0]   valid = '0;
   logic [N*W-1:0] data = '0;
   logic           fifo_read = 1'b0;
   logic           busy = 1'b0;

   logic [N-1:0]   ready;
   logic [W-1:0]   tx_data;
   logic           tx_empty, tx_start, done, arb_busy;
   logic [1:0]     gid;

   always #5 clk = ~clk;

   spi_tx_arbiter #(
      .NUM_REQ    (N),
      .DATA_W     (W),
      .GAP_CYCLES (G)
   ) dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .enable_i        (en),
      .req_valid_i     (valid),
      .req_data_i      (data),
      .req_ready_o     (ready),
      .tx_data_o       (tx_data),
      .tx_fifo_empty_o (tx_empty),
      .tx_start_o      (tx_start),
      .tx_fifo_read_i  (fifo_read),
      .tx_spi_busy_i   (busy),
      .grant_id_o      (gid),
      .frame_done_o    (done),
      .arb_busy_o      (arb_busy)
   );

   int total = 0;
   int bad = 0;
   int cyc_g = 0;

   // Model: a frame is owned or not; once it ends, G idle cycles must pass.
   bit           m_in_frame;
   bit           m_popped;
   logic [W-1:0] m_word;
   int           m_grant;
   int           m_last;
   int           m_gap;

   // Transmitter stand-in.
   int pop_cnt = -1;
   int busy_cnt = 0;
   int delay_v, len_v;

   bit           idle, acc, e_start, e_done;
   int           g;
   logic [N-1:0] e_ready;
   int           grant_log[$];
   int           exp_order[6] = '{0, 1, 2, 3, 0, 1};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_g, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin
      m_in_frame = 0; m_popped = 0; m_word = '0; m_grant = 0; m_last = N - 1; m_gap = 0;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         cyc_g = c;
         if (c < 2 || c == 40 || c == 41) rst = 1'b1;
         else if (c >= 200 && $urandom_range(0, 299) == 0) rst = 1'b1;
         else rst = 1'b0;
         for (int r = 0; r < N; r++) data[r*W +: W] = W'($urandom);
         if (c < 40) begin
            en = 1'b1; valid = 4'b0100; data[2*W +: W] = 24'hA5C3F0;
            delay_v = 0; len_v = 24;
         end else if (c < 200) begin
            en = 1'b1; valid = '1;
            delay_v = 0; len_v = 3;
         end else begin
            en = ($urandom_range(0, 7) != 0);
            valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) valid = '0;
            delay_v = $urandom_range(0, 3); len_v = $urandom_range(1, 6);
         end
         if (rst) begin
            fifo_read = 1'b0; busy = 1'b0;
         end else begin
            fifo_read = (pop_cnt == 0); busy = (busy_cnt > 0);
         end
         #1;
         idle    = !m_in_frame && (m_gap == 0);
         g       = pick(valid, m_last);
         acc     = !rst && idle && en && (g >= 0);
         e_ready = acc ? N'(1 << g) : '0;
         e_start = m_in_frame && !m_popped;
         e_done  = !rst && m_in_frame && m_popped && !busy;
         chk("req_ready", ready, e_ready);
         chk("tx_start", tx_start, e_start);
         chk("tx_fifo_empty", tx_empty, !e_start);
         chk("frame_done", done, e_done);
         chk("arb_busy", arb_busy, !idle);
         chk("tx_data", tx_data, m_word);
         chk("grant_id", gid, m_grant);

         if (c == 2) chk("t1_ready_c0", ready, 4'b0100);
         if (c == 3) begin
            chk("t1_start_c1", tx_start, 1);
            chk("t1_data", tx_data, 24'hA5C3F0);
            chk("t1_gid", gid, 2);
         end
         if (c == 5) chk("t1_empty_after_pop", tx_empty, 1);
         if (c == 28) chk("t1_done_early", done, 0);
         if (c == 29) chk("t1_done_c27", done, 1);
         if (c == 31) begin
            chk("t1_gap_ready", ready, 0);
            chk("t1_gap_busy", arb_busy, 1);
         end
         if (c == 32) chk("t1_regrant_c30", ready, 4'b0100);
         if (c == 40) chk("t5_no_done", done, 0);
         if (c == 41) begin
            chk("t5_ready", ready, 0);
            chk("t5_data", tx_data, 0);
            chk("t5_empty", tx_empty, 1);
            chk("t5_start", tx_start, 0);
            chk("t5_arb_busy", arb_busy, 0);
            chk("t5_gid", gid, 0);
         end
         if (c == 42) chk("t2_first_rr0", ready, 4'b0001);
         if (c >= 42 && c < 200) begin
            for (int r = 0; r < N; r++) if (ready[r]) grant_log.push_back(r);
         end

         if (rst) begin
            m_in_frame = 0; m_popped = 0; m_word = '0; m_grant = 0; m_last = N - 1; m_gap = 0;
         end else if (acc) begin
            m_in_frame = 1; m_popped = 0; m_word = data[g*W +: W]; m_grant = g; m_last = g;
         end else if (e_start) begin
            if (fifo_read) m_popped = 1;
         end else if (e_done) begin
            m_in_frame = 0; m_gap = G;
         end else if (!m_in_frame && m_gap > 0) begin
            m_gap--;
         end

         if (rst) begin
            pop_cnt = -1; busy_cnt = 0;
         end else if (pop_cnt == 0) begin
            pop_cnt = -1; busy_cnt = len_v;
         end else if (pop_cnt > 0) begin
            pop_cnt--;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end else if (tx_start) begin
            pop_cnt = delay_v;
         end
      end

      chk("t2_log_len", (grant_log.size() >= 6), 1);
      if (grant_log.size() >= 6) begin
         for (int i = 0; i < 6; i++) chk("t2_order", grant_log[i], exp_order[i]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
